// File: rtl/ide_pkg.sv
// Shared definitions for the IDE PIO sequencer: FSM encoding, task-file register map, default strobe timing.
// Pure declarations; no latency or backpressure of its own.
// Consumers import with ide_pkg::*.
package ide_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Command block (CS0) register addresses
    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_ERROR    = 3'd1;
    localparam logic [2:0] REG_FEATURES = 3'd1;
    localparam logic [2:0] REG_SECCNT   = 3'd2;
    localparam logic [2:0] REG_LBA0     = 3'd3;
    localparam logic [2:0] REG_LBA1     = 3'd4;
    localparam logic [2:0] REG_LBA2     = 3'd5;
    localparam logic [2:0] REG_DRVHEAD  = 3'd6;
    localparam logic [2:0] REG_STATUS   = 3'd7;
    localparam logic [2:0] REG_CMD      = 3'd7;

    // Control block (CS1) shares da=6 between ALTSTATUS (read) and DEVCTL (write)
    localparam logic [2:0] REG_ALTSTATUS = 3'd6;
    localparam logic [2:0] REG_DEVCTL    = 3'd6;

    localparam logic BLK_CMD = 1'b0;
    localparam logic BLK_CTL = 1'b1;

    localparam int unsigned T_SETUP_DEF = 3;
    localparam int unsigned T_PULSE_DEF = 8;
    localparam int unsigned T_HOLD_DEF  = 2;

    localparam int unsigned MAX_WORDS = 256;

    function automatic logic [3:0] cnt_load(input int unsigned cycles);
        return 4'(cycles - 1);
    endfunction

    function automatic logic [1:0] cs_decode(input logic blk);
        return (blk == BLK_CTL) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/ide_pio_ctrl.sv
// PIO sequencer for the IDE register/data port: setup, strobe and hold phases per word, bursts up to 256 words.
// Latency: T_SETUP+T_PULSE+T_HOLD cycles per word from accept to done, plus any write-data stall.
// Backpressure: a write word stalls in the last setup cycle until wvalid; wready is the combinational take.
module ide_pio_ctrl
    import ide_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [8:0]  len,
    input  logic [15:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        done,
    input  logic [15:0] ide_din,
    output logic [15:0] ide_dout,
    output logic        ide_oe,
    output logic        ide_dior,
    output logic        ide_diow,
    output logic [1:0]  ide_cs,
    output logic [2:0]  ide_da
);

    state_t      state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [8:0]  remain_q, remain_d;
    logic        we_q,     we_d;
    logic [3:0]  addr_q,   addr_d;

    logic [15:0] ide_dout_q, ide_dout_d;
    logic        ide_oe_q,   ide_oe_d;
    logic        ide_dior_q, ide_dior_d;
    logic        ide_diow_q, ide_diow_d;
    logic [1:0]  ide_cs_q,   ide_cs_d;
    logic [2:0]  ide_da_q,   ide_da_d;
    logic [15:0] rdata_q,    rdata_d;
    logic        rvalid_q,   rvalid_d;
    logic        done_q,     done_d;

    logic        take_w;
    logic [8:0]  remain_dec;

    assign remain_dec = remain_q - 9'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            remain_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            ide_dout_q <= '0;
            ide_oe_q   <= 1'b0;
            ide_dior_q <= 1'b1;
            ide_diow_q <= 1'b1;
            ide_cs_q   <= 2'b11;
            ide_da_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            remain_q   <= remain_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            ide_dout_q <= ide_dout_d;
            ide_oe_q   <= ide_oe_d;
            ide_dior_q <= ide_dior_d;
            ide_diow_q <= ide_diow_d;
            ide_cs_q   <= ide_cs_d;
            ide_da_q   <= ide_da_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        remain_d = remain_q;
        we_d     = we_q;
        addr_d   = addr_q;
        take_w   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d     = we;
                    addr_d   = addr;
                    remain_d = (len == 9'd0) ? 9'd1 : len;
                    cnt_d    = cnt_load(T_SETUP);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!we_q) begin
                    cnt_d   = cnt_load(T_PULSE);
                    state_d = ST_STROBE;
                end else if (wvalid) begin
                    // Write word is taken only at the end of setup; until then strobes stay high.
                    take_w  = 1'b1;
                    cnt_d   = cnt_load(T_PULSE);
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = cnt_load(T_HOLD);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    remain_d = remain_dec;
                    if (remain_dec != 9'd0) begin
                        cnt_d   = cnt_load(T_SETUP);
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin outputs are computed from the next state so the registered pins line up with the state.
    always_comb begin
        ide_cs_d   = 2'b11;
        ide_da_d   = 3'd0;
        ide_dior_d = 1'b1;
        ide_diow_d = 1'b1;
        ide_oe_d   = 1'b0;
        ide_dout_d = ide_dout_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        done_d     = 1'b0;

        if (state_d != ST_IDLE) begin
            ide_cs_d = cs_decode(addr_d[3]);
            ide_da_d = addr_d[2:0];
        end

        if (state_d == ST_STROBE) begin
            if (we_d) begin
                ide_diow_d = 1'b0;
            end else begin
                ide_dior_d = 1'b0;
            end
        end

        if (we_d && ((state_d == ST_STROBE) || (state_d == ST_HOLD))) begin
            ide_oe_d = 1'b1;
        end

        if (take_w) begin
            ide_dout_d = wdata;
        end

        if ((state_q == ST_STROBE) && (cnt_q == 4'd0) && !we_q) begin
            rdata_d  = ide_din;
            rvalid_d = 1'b1;
        end

        if ((state_q == ST_HOLD) && (cnt_q == 4'd0) && (remain_dec == 9'd0)) begin
            done_d = 1'b1;
        end
    end

    assign wready   = take_w;
    assign busy     = (state_q != ST_IDLE);
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign done     = done_q;
    assign ide_dout = ide_dout_q;
    assign ide_oe   = ide_oe_q;
    assign ide_dior = ide_dior_q;
    assign ide_diow = ide_diow_q;
    assign ide_cs   = ide_cs_q;
    assign ide_da   = ide_da_q;

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Bench for ide_pio_ctrl: directed and random accesses checked cycle by cycle against a phase-timeline model.
// The model places each word as setup/strobe/hold windows from the timing parameters and stall plan.
module tb_ide_pio_ctrl;

    localparam int TS = 3;
    localparam int TP = 8;
    localparam int TH = 2;
    localparam int TW = TS + TP + TH;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [8:0]  len = '0;
    logic [15:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        done;
    logic [15:0] ide_din = '0;
    logic [15:0] ide_dout;
    logic        ide_oe;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [15:0] din_hist [0:4095];
    logic [15:0] wq [0:255];

    always #5 clk = ~clk;

    ide_pio_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .rdata(rdata), .rvalid(rvalid),
        .busy(busy), .done(done), .ide_din(ide_din), .ide_dout(ide_dout), .ide_oe(ide_oe),
        .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Place cycle c of an access on its word and phase: 0 setup, 1 strobe, 2 hold, 3 after last word.
    function automatic void locate(input int c, input int n, input int sj, input int sn,
                                   output int k, output int ph, output int off);
        int t;
        int sl;
        t = c;
        k = n; ph = 3; off = 0;
        for (int i = 0; i < n; i++) begin
            sl = TS + ((i == sj) ? sn : 0);
            if (t < sl) begin k = i; ph = 0; off = t; return; end
            t -= sl;
            if (t < TP) begin k = i; ph = 1; off = t; return; end
            t -= TP;
            if (t < TH) begin k = i; ph = 2; off = t; return; end
            t -= TH;
        end
    endfunction

    // dmode: 0 random data, 1 fixed (din 0058 / wdata 0002), 2 incrementing din
    task automatic access(input bit w, input logic [3:0] a, input logic [8:0] l,
                          input int sj, input int sn, input int dmode, input string tag);
        int n;
        int dcyc;
        int widx;
        int rcnt;
        int k, ph, off, sl;
        logic [1:0]  sel;
        logic [11:0] ev, ov;
        n    = (l == 9'd0) ? 1 : int'(l);
        dcyc = n * TW + ((sj >= 0 && sj < n) ? sn : 0);
        widx = 0;
        rcnt = 0;
        sel  = a[3] ? 2'b01 : 2'b10;
        for (int i = 0; i < n; i++) wq[i] = (dmode == 1) ? 16'h0002 : 16'($urandom);
        req = 1'b1; we = w; addr = a; len = l;
        for (int c = 0; c <= dcyc; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
            locate(c, n, sj, sn, k, ph, off);
            wvalid  = w && !(k == sj && ph == 0 && off >= TS - 1 && off < TS - 1 + sn);
            wdata   = wq[(widx < n) ? widx : n - 1];
            ide_din = (dmode == 1) ? 16'h0058 : (dmode == 2) ? 16'(c) : 16'($urandom);
            din_hist[c] = ide_din;
            @(negedge clk);
            sl = TS + ((k == sj) ? sn : 0);
            if (ph == 3)
                ev = {2'b11, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            else
                ev = {sel, a[2:0], !(ph == 1 && !w), !(ph == 1 && w), (w && ph != 0),
                      (!w && ph == 2 && off == 0), 1'b0, (w && ph == 0 && off == sl - 1), 1'b1};
            ov = {ide_cs, ide_da, ide_dior, ide_diow, ide_oe, rvalid, done, wready, busy};
            check($sformatf("%s pins c%0d", tag, c), 32'(ov), 32'(ev));
            if (!w && ph == 2 && off == 0) begin
                check($sformatf("%s rdata w%0d", tag, k), 32'(rdata), 32'(din_hist[c - 1]));
                rcnt++;
            end
            if (w && (ph == 1 || ph == 2))
                check($sformatf("%s dout w%0d c%0d", tag, k, c), 32'(ide_dout), 32'(wq[k]));
            if (wready) widx++;
        end
        wvalid = 1'b0;
        check($sformatf("%s wready count", tag), 32'(widx), 32'(w ? n : 0));
        check($sformatf("%s rvalid count", tag), 32'(rcnt), 32'(w ? 0 : n));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        bit          rw;
        bit          chain;
        logic [8:0]  rl;
        int          rn, rsj, rsn;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset pins", 32'({ide_cs, ide_da, ide_dior, ide_diow, ide_oe, rvalid, done, wready, busy}),
              32'(12'b11_000_1_1_0_0_0_0_0));
        check("reset dout", 32'(ide_dout), 32'h0);
        check("reset rdata", 32'(rdata), 32'h0);
        reset_n = 1'b1;
        idle(2);

        // Single read of STATUS, single write of DEVCTL
        access(1'b0, 4'h7, 9'd1, -1, 0, 1, "rd_status");
        check("rd_status rdata held", 32'(rdata), 32'h0058);
        idle(2);
        access(1'b1, 4'hE, 9'd1, -1, 0, 1, "wr_devctl");
        idle(2);

        // Full-sector read and stalled write burst
        access(1'b0, 4'h0, 9'd256, -1, 0, 2, "burst_rd");
        idle(2);
        access(1'b1, 4'h0, 9'd4, 2, 5, 0, "burst_wr");
        idle(2);

        // Reset mid-strobe
        req = 1'b1; we = 1'b0; addr = 4'h7; len = 9'd1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid strobe dior", 32'(ide_dior), 32'h0);
        reset_n = 1'b0;
        #1;
        check("arst pins", 32'({ide_cs, ide_da, ide_dior, ide_diow, ide_oe, rvalid, done, wready, busy}),
              32'(12'b11_000_1_1_0_0_0_0_0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("arst no done %0d", i), 32'({done, busy}), 32'h0);
        end
        reset_n = 1'b1;
        idle(1);
        access(1'b0, 4'h3, 9'd2, -1, 0, 0, "after_rst");
        idle(1);

        // len=0 with a back-to-back request in the done cycle
        access(1'b1, 4'h1, 9'd0, -1, 0, 0, "len0_wr");
        access(1'b0, 4'h7, 9'd1, -1, 0, 0, "b2b_rd");
        idle(2);

        // Random accesses
        for (int t = 0; t < 12; t++) begin
            rw    = 1'($urandom_range(0, 1));
            rl    = 9'($urandom_range(0, 6));
            rn    = (rl == 9'd0) ? 1 : int'(rl);
            rsj   = rw ? int'($urandom_range(0, rn)) : -1;
            rsn   = int'($urandom_range(1, 6));
            chain = 1'($urandom_range(0, 1));
            access(rw, 4'($urandom), rl, rsj, rsn, 0, $sformatf("rand%0d", t));
            if (!chain) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
